cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates the single Common Data Bus (CDB) among the execution units of the out-of-order core. Each unit hands a completed result (tag + data) over a valid/ready handshake into a one-entry holding slot. A round-robin arbiter picks one occupied slot per cycle and drives the registered CDB broadcast (`cdb_valid`, `cdb_tag`, `cdb_data`). That broadcast feeds the register status table's tag-clear and write-back path and the reservation stations.

## Interface
Parameters:
- `N_REQ`, 4: number of requesting execution units. Index 0 = INT, 1 = MUL, 2 = DIV, 3 = LD/ST.
- `TAG_W`, 6: width of a result tag.
- `DATA_W`, 32: width of a result value.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous pipeline flush (mispredict or exception).
- `req_valid`  in  N_REQ  unit i offers a result.
- `req_tag`  in  N_REQ*TAG_W  packed tags; unit i occupies bits [i*TAG_W +: TAG_W].
- `req_data`  in  N_REQ*DATA_W  packed results; unit i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  slot i can accept a result this cycle.
- `cdb_valid`  out  1  CDB carries a valid broadcast.
- `cdb_tag`  out  TAG_W  broadcast tag.
- `cdb_data`  out  DATA_W  broadcast result.

## Operation
- State per requester: `hold_valid[i]`, `hold_tag[i]`, `hold_data[i]`. Global state: round-robin pointer `rr_ptr` (log2 N_REQ bits) and the CDB output registers.
- Grant is combinational from registered state. `grant[i]` = the first `i` with `hold_valid[i]` set, searching `rr_ptr`, `rr_ptr+1`, … with modulo-N_REQ wrap. At most one grant per cycle. No grant when no slot is occupied.
- `req_ready[i]` = `rst` high AND `!flush` AND (`!hold_valid[i]` OR `grant[i]`). It depends only on registered state, `flush` and `rst`, never on `req_valid`.
- Accept: `req_valid[i] && req_ready[i]` at an edge loads slot i and sets `hold_valid[i]`. A granted slot can be cleared and reloaded at the same edge; the new entry wins.
- Broadcast at each edge when not flushing:
  - Grant g exists: `cdb_valid` <= 1, `cdb_tag`/`cdb_data` <= slot g, `hold_valid[g]` <= 0 unless reloaded, `rr_ptr` <= (g+1) mod N_REQ.
  - No grant: `cdb_valid` <= 0, `cdb_tag`/`cdb_data` hold their previous values, `rr_ptr` unchanged.
- Flush edge:
  - All `hold_valid` <= 0 and `cdb_valid` <= 0.
  - No accept occurs (`req_ready` is 0).
  - `rr_ptr` and `cdb_tag`/`cdb_data` are unchanged.
- Reset edge (`rst` low): `hold_valid` = 0, `rr_ptr` = 0, `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0. Reset overrides flush, accept and grant. `req_ready` reads 0 while `rst` is low and all-ones on the first cycle after release.
- Tag and data are passed through unmodified; the block does no tag check and no width conversion.
- No starvation: an occupied slot is granted within N_REQ cycles.

## Timing
- Latency: accepted at edge t, visible on the CDB after edge t+1 at the earliest, so exactly one cycle in the holding slot when uncontended.
- Throughput: one broadcast per cycle in aggregate. A single unit alone sustains one result per cycle, because `req_ready` stays high while its slot is granted.
- Worst-case wait with all N_REQ slots occupied is N_REQ-1 cycles after becoming eligible.
- `cdb_valid` is a one-cycle pulse per result. Back-to-back pulses occur whenever slots stay occupied.
- Outputs are registered; no combinational path runs from `req_*` to `cdb_*`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with all `req_valid`=1.
  - During reset: `req_ready`=0000, `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0.
  - First cycle after release: `req_ready`=1111.
- **Single unit streaming:** unit 1 presents tags 0x05, 0x06, 0x07 on consecutive cycles.
  - `req_ready[1]` stays 1.
  - `cdb_valid`=1 for 3 consecutive cycles, starting one cycle after the first accept, with tags 05, 06, 07 in order.
- **Round-robin fairness:** all four units offer one result in the same cycle (tags 0x10..0x13), with `rr_ptr`=0.
  - CDB order is 10, 11, 12, 13 on four consecutive cycles.
  - `rr_ptr` ends at 0.
  - Repeat with `rr_ptr`=2: order is 12, 13, 10, 11.
- **Backpressure:** units 0 and 2 keep `req_valid` high with tags A0, A1 (unit 0) and B0, B1 (unit 2).
  - The non-granted slot shows `req_ready`=0 while occupied.
  - All four tags appear exactly once, alternating between the two units; none are lost or duplicated.
- **Flush:** occupy slots 0, 1 and 3, then assert `flush` for one cycle.
  - Next cycle: `cdb_valid`=0 and `req_ready`=1111.
  - None of the flushed tags ever appears on the CDB.
  - A result accepted after the flush broadcasts normally.
- **Reset mid-operation:** assert `rst`=0 while all slots are occupied and `cdb_valid`=1.
  - All outputs return to their reset values at the next edge.
  - No pre-reset tag appears on the CDB after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry holding slot per execution unit, round-robin grant
// onto a registered Common Data Bus broadcast.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  hold_valid;
  logic [TAG_W-1:0]  hold_tag [N_REQ];
  logic [DATA_W-1:0] hold_data [N_REQ];
  logic [PW-1:0]     rr_ptr;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic [PW-1:0]     gnt;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     nxt_ptr;
  logic              found;

  // first occupied slot at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    grant = '0;
    gnt = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && hold_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign nxt_ptr   = PW'((int'(gnt) + 1) % N_REQ);
  assign req_ready = {N_REQ{rst & ~flush}} & (~hold_valid | grant);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid <= '0;
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= found;
      if (found) begin
        cdb_tag <= hold_tag[gnt];
        cdb_data <= hold_data[gnt];
        rr_ptr <= nxt_ptr;
      end
      for (int i = 0; i < N_REQ; i++)
        hold_valid[i] <= accept[i] ? 1'b1 : (grant[i] ? 1'b0 : hold_valid[i]);
    end
  end

  // payload needs no reset: it is only observed behind hold_valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++)
      if (accept[i]) begin
        hold_tag[i] <= req_tag[i*TAG_W +: TAG_W];
        hold_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors, hand-written corner sequences and random
// traffic checked against a behavioural model of the arbiter.
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  v = '0;
  logic [5:0]  t [4] = '{default: '0};
  logic [23:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [3:0] rdy_s;
  logic [5:0] seen [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] dfun(input logic [5:0] x);
    return 32'({26'd0, x} * 32'h0101_0101);
  endfunction

  assign req_tag  = {t[3], t[2], t[1], t[0]};
  assign req_data = {dfun(t[3]), dfun(t[2]), dfun(t[1]), dfun(t[0])};

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(v), .req_tag(req_tag),
    .req_data(req_data), .req_ready(req_ready), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  // behavioural model: slots as arrays, pointer as a plain integer
  bit          m_hv [4];
  logic [5:0]  m_tag [4];
  logic [31:0] m_data [4];
  int          m_ptr;
  bit          m_cv;
  logic [5:0]  m_ctag;
  logic [31:0] m_cdata;

  function automatic int m_grant();
    for (int k = 0; k < 4; k++)
      if (m_hv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r = '0;
    int g = m_grant();
    if (rst && !flush)
      for (int i = 0; i < 4; i++) r[i] = !m_hv[i] || (g == i);
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] r = m_ready();
    int g = m_grant();
    if (!rst) begin
      m_hv = '{default: 0};
      m_ptr = 0; m_cv = 0; m_ctag = '0; m_cdata = '0;
    end else if (flush) begin
      m_hv = '{default: 0};
      m_cv = 0;
    end else begin
      m_cv = (g >= 0);
      if (g >= 0) begin
        m_ctag = m_tag[g]; m_cdata = m_data[g];
        m_hv[g] = 0;
        m_ptr = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (v[i] && r[i]) begin
          m_hv[i] = 1; m_tag[i] = t[i]; m_data[i] = dfun(t[i]);
        end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (chk_en) begin
      chk("model_ready", 32'(req_ready), 32'(m_ready()));
      chk("model_cdb_valid", 32'(cdb_valid), 32'(m_cv));
      chk("model_cdb_tag", 32'(cdb_tag), 32'(m_ctag));
      chk("model_cdb_data", cdb_data, m_cdata);
    end
    rdy_s = req_ready;
    if (cdb_valid) seen.push_back(cdb_tag);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    sample();
    edge_step();
  endtask

  typedef struct {
    bit         r;
    logic [3:0] v;
    logic [23:0] tg;
    logic [3:0] rdy;
    bit         cv;
    logic [5:0] tag;
  } vec_t;

  function automatic vec_t mk(input bit r, input logic [3:0] vv, input logic [23:0] tg,
                              input logic [3:0] rdy, input bit cv, input logic [5:0] tag);
    vec_t x;
    x.r = r; x.v = vv; x.tg = tg; x.rdy = rdy; x.cv = cv; x.tag = tag;
    return x;
  endfunction

  initial begin
    vec_t tbl [$];
    logic [5:0] at [2] = '{6'h0A, 6'h1A};
    logic [5:0] bt [2] = '{6'h0B, 6'h1B};
    logic [5:0] exp_bp [4] = '{6'h0A, 6'h0B, 6'h1A, 6'h1B};
    int a = 0;
    int b = 0;
    // reset, single-unit streaming, round robin from pointer 2 then 0
    tbl.push_back(mk(0, 4'hF, {6'h3F, 6'h3F, 6'h3F, 6'h3F}, 4'h0, 0, 6'h00));
    tbl.push_back(mk(0, 4'hF, {6'h3F, 6'h3F, 6'h3F, 6'h3F}, 4'h0, 0, 6'h00));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 0, 6'h00));
    tbl.push_back(mk(1, 4'b0010, {6'h0, 6'h0, 6'h05, 6'h0}, 4'hF, 0, 6'h00));
    tbl.push_back(mk(1, 4'b0010, {6'h0, 6'h0, 6'h06, 6'h0}, 4'hF, 0, 6'h00));
    tbl.push_back(mk(1, 4'b0010, {6'h0, 6'h0, 6'h07, 6'h0}, 4'hF, 1, 6'h05));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 1, 6'h06));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 1, 6'h07));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 0, 6'h07));
    tbl.push_back(mk(1, 4'hF, {6'h13, 6'h12, 6'h11, 6'h10}, 4'hF, 0, 6'h07));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'b0100, 0, 6'h07));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'b1100, 1, 6'h12));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'b1101, 1, 6'h13));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 1, 6'h10));
    tbl.push_back(mk(1, 4'b1000, {6'h20, 6'h0, 6'h0, 6'h0}, 4'hF, 1, 6'h11));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 0, 6'h11));
    tbl.push_back(mk(1, 4'hF, {6'h13, 6'h12, 6'h11, 6'h10}, 4'hF, 1, 6'h20));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'b0001, 0, 6'h20));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'b0011, 1, 6'h10));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'b0111, 1, 6'h11));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 1, 6'h12));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 1, 6'h13));
    tbl.push_back(mk(1, 4'b1010, {6'h33, 6'h0, 6'h31, 6'h0}, 4'hF, 0, 6'h13));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'b0111, 0, 6'h13));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 1, 6'h31));
    tbl.push_back(mk(1, 4'h0, 24'h0, 4'hF, 1, 6'h33));

    rst = 1'b0; v = 4'hF;
    edge_step();
    chk_en = 1'b1;
    foreach (tbl[n]) begin
      rst = tbl[n].r; v = tbl[n].v;
      for (int i = 0; i < 4; i++) t[i] = tbl[n].tg[i*6 +: 6];
      sample();
      chk($sformatf("tbl%0d_ready", n), 32'(req_ready), 32'(tbl[n].rdy));
      chk($sformatf("tbl%0d_valid", n), 32'(cdb_valid), 32'(tbl[n].cv));
      chk($sformatf("tbl%0d_tag", n), 32'(cdb_tag), 32'(tbl[n].tag));
      chk($sformatf("tbl%0d_data", n), cdb_data, dfun(tbl[n].tag));
      edge_step();
    end

    // backpressure: units 0 and 2 stream two results each
    v = '0; t = '{default: '0};
    seen.delete();
    for (int c = 0; c < 12; c++) begin
      v[0] = (a < 2); v[2] = (b < 2);
      t[0] = (a < 2) ? at[a] : 6'h0;
      t[2] = (b < 2) ? bt[b] : 6'h0;
      sample();
      if (c == 1) chk("bp_ready2_blocked", 32'(req_ready[2]), 32'd0);
      if (c == 2) chk("bp_ready0_blocked", 32'(req_ready[0]), 32'd0);
      edge_step();
      if (v[0] && rdy_s[0]) a++;
      if (v[2] && rdy_s[2]) b++;
    end
    v = '0;
    chk("bp_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_order%0d", i), (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF, 32'(exp_bp[i]));

    // flush with slots 0, 1, 3 occupied
    seen.delete();
    v = 4'b1011; t = '{6'h21, 6'h22, 6'h0, 6'h23};
    tick();
    v = '0; flush = 1'b1;
    sample();
    chk("flush_ready_low", 32'(req_ready), 32'h0);
    edge_step();
    flush = 1'b0;
    sample();
    chk("post_flush_valid", 32'(cdb_valid), 32'd0);
    chk("post_flush_ready", 32'(req_ready), 32'hF);
    edge_step();
    repeat (4) tick();
    v = 4'b0010; t[1] = 6'h24;
    tick();
    v = '0;
    repeat (3) tick();
    chk("flush_seen_count", 32'(seen.size()), 32'd1);
    chk("flush_seen_tag", (seen.size() > 0) ? 32'(seen[0]) : 32'hFFFF, 32'h24);

    // reset while all slots busy and the bus is active
    v = 4'hF; t = '{6'h30, 6'h31, 6'h32, 6'h33};
    tick(); tick();
    sample();
    chk("mid_busy_valid", 32'(cdb_valid), 32'd1);
    edge_step();
    rst = 1'b0;
    sample();
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    edge_step();
    rst = 1'b1; v = '0;
    seen.delete();
    sample();
    chk("mid_rst_valid", 32'(cdb_valid), 32'd0);
    chk("mid_rst_tag", 32'(cdb_tag), 32'd0);
    chk("mid_rst_data", cdb_data, 32'd0);
    chk("mid_rst_ready1", 32'(req_ready), 32'hF);
    edge_step();
    repeat (6) tick();
    chk("mid_rst_no_stale", 32'(seen.size()), 32'd0);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) != 0);
      flush = ($urandom_range(15) == 0);
      v = 4'($urandom);
      for (int i = 0; i < 4; i++) t[i] = 6'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
